// File: rtl/hcr_loopback_fifo.sv
// Loopback FIFO between the Xillybus hcw (host-to-FPGA) and hcr (FPGA-to-host) streams.
// Adds EOF generation once the write side closes and drains, plus debug counters and flags.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | no write session; eof low
//   S_STREAM | write device open, words flowing
//   S_DRAIN  | write device closed, waiting for the buffer to empty
//   S_EOF    | write closed and buffer empty; eof high until reopen/close
module hcr_loopback_fifo #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              bus_clk,
    input  logic              reset,
    input  logic              user_w_hcw_wren,
    input  logic [DATA_W-1:0] user_w_hcw_data,
    output logic              user_w_hcw_full,
    input  logic              user_w_hcw_open,
    input  logic              user_r_hcr_rden,
    output logic [DATA_W-1:0] user_r_hcr_data,
    output logic              user_r_hcr_empty,
    output logic              user_r_hcr_eof,
    input  logic              user_r_hcr_open,
    output logic [31:0]       word_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_EOF
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   occ;
    logic              w_open_q;
    logic              r_open_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              w_rise;
    logic              flush;
    state_t            state;
    state_t            state_nxt;

    assign user_w_hcw_full  = (occ == OCC_FULL);
    assign user_r_hcr_empty = (occ == '0);
    assign wr_acc = user_w_hcw_wren && !user_w_hcw_full;
    assign rd_acc = user_r_hcr_rden && !user_r_hcr_empty;
    assign w_rise = user_w_hcw_open && !w_open_q;
    assign flush  = r_open_q && !user_r_hcr_open;

    // RAM kept free of reset so it maps onto block memory.
    always_ff @(posedge bus_clk) begin
        if (wr_acc) begin
            mem[wptr] <= user_w_hcw_data;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            wptr            <= '0;
            rptr            <= '0;
            occ             <= '0;
            w_open_q        <= 1'b0;
            r_open_q        <= 1'b0;
            user_r_hcr_data <= '0;
            word_count      <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            w_open_q <= user_w_hcw_open;
            r_open_q <= user_r_hcr_open;
            if (user_w_hcw_wren && user_w_hcw_full) begin
                overflow <= 1'b1;
            end
            if (user_r_hcr_rden && user_r_hcr_empty) begin
                underflow <= 1'b1;
            end
            if (rd_acc) begin
                user_r_hcr_data <= mem[rptr];
            end
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                occ  <= '0;
            end else begin
                if (wr_acc) begin
                    wptr <= wptr + 1'b1;
                end
                if (rd_acc) begin
                    rptr <= rptr + 1'b1;
                end
                if (wr_acc && !rd_acc) begin
                    occ <= occ + 1'b1;
                end else if (rd_acc && !wr_acc) begin
                    occ <= occ - 1'b1;
                end
            end
            if (w_rise) begin
                word_count <= '0;
            end else if (wr_acc && word_count != 32'hFFFF_FFFF) begin
                word_count <= word_count + 32'd1;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state          <= S_IDLE;
            user_r_hcr_eof <= 1'b0;
        end else begin
            state          <= state_nxt;
            user_r_hcr_eof <= (state_nxt == S_EOF);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (user_w_hcw_open) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (!user_w_hcw_open) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (user_w_hcw_open) begin
                    state_nxt = S_STREAM;
                end else if (occ == '0 && !rd_acc) begin
                    state_nxt = S_EOF;
                end
            end
            S_EOF: begin
                if (user_w_hcw_open) begin
                    state_nxt = S_STREAM;
                end else if (!user_r_hcr_open) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush && !user_w_hcw_open) begin
            state_nxt = S_IDLE;
        end
    end

endmodule

// File: doc/hcr_loopback_fifo.md
Name: hcr_loopback_fifo

Overview:
- Sits between the Xillybus core's host-to-FPGA stream (hcw) and its FPGA-to-host stream (hcr).
- Buffers 32-bit words written by the core on user_w_hcw_* and presents them back on user_r_hcr_* with standard-FIFO read semantics.
- Generates EOF toward the host once the write side has closed and the buffer has drained.
- Also provides a per-session word counter and sticky error flags for debug and the LEDs.

Parameters:
- ADDR_W, 9, log2 of FIFO depth; DEPTH = 2^ADDR_W words (default 512).
- DATA_W, 32, word width; must match the core stream width.

Ports:
- bus_clk  input  1  sole clock, core bus clock domain.
- reset  input  1  synchronous, active-high reset.
- user_w_hcw_wren  input  1  write strobe from core.
- user_w_hcw_data  input  DATA_W  write data from core.
- user_w_hcw_full  output  1  FIFO full, to core.
- user_w_hcw_open  input  1  host has the write device open.
- user_r_hcr_rden  input  1  read strobe from core.
- user_r_hcr_data  output  DATA_W  read data, valid the cycle after an accepted rden.
- user_r_hcr_empty  output  1  FIFO empty, to core.
- user_r_hcr_eof  output  1  end-of-file indication, to core.
- user_r_hcr_open  input  1  host has the read device open.
- word_count  output  32  words accepted since the last write-open rising edge.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Interface: one clock (bus_clk). reset is synchronous and active-high.
- Reset values:
  - read/write pointers = 0, occupancy count = 0.
  - user_w_hcw_full = 0, user_r_hcr_empty = 1, user_r_hcr_eof = 0.
  - user_r_hcr_data = 0, word_count = 0, overflow = underflow = 0, FSM = IDLE.
- Storage: DEPTH x DATA_W dual-pointer RAM (inferable). occ is ADDR_W+1 bits.
  - full = (occ == DEPTH); empty = (occ == 0). Both are derived from the registered occ, with no lookahead.
- Write accept: wren && !full. Data goes to mem[wptr]; wptr wraps modulo DEPTH.
  - wren && full: word dropped, overflow <= 1. This holds even if a read is accepted in the same cycle.
- Read accept: rden && !empty. user_r_hcr_data <= mem[rptr] on the next edge (1-cycle latency); rptr wraps modulo DEPTH.
  - rden && empty: ignored, data holds, underflow <= 1. This holds even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: occ unchanged, ordering preserved.
- Occupancy update: occ changes by +1 on write only, -1 on read only.
- word_count:
  - Cleared on the cycle after the user_w_hcw_open rising edge.
  - Increments per accepted write; saturates at 0xFFFFFFFF.
- Read-side close (user_r_hcr_open 1->0): FIFO flushed next cycle (pointers = 0, occ = 0). Sticky flags are not cleared.
- Sticky flags clear only on reset.
- EOF FSM, states IDLE / STREAM / DRAIN / EOF:
  - IDLE: eof = 0. Goes to STREAM when user_w_hcw_open = 1.
  - STREAM: eof = 0. Goes to DRAIN when user_w_hcw_open = 0.
  - DRAIN: eof = 0.
    - Goes to STREAM if user_w_hcw_open returns to 1.
    - Else goes to EOF when occ == 0 and no read is accepted this cycle.
  - EOF: eof = 1 (registered, asserted the cycle after entry, coincident with empty = 1).
    - Goes to STREAM if user_w_hcw_open = 1; eof drops the next cycle.
    - Else goes to IDLE when user_r_hcr_open = 0.
  - From any state, a read-close flush with user_w_hcw_open = 0 forces the FSM to IDLE.
- Writes arriving while the write side is not open are still accepted (the core never issues them).
- Reset mid-operation: all state returns to reset values on the next edge. In-flight data is discarded.

Test Plan:
- Both sides open; write 0x11, 0x22, 0x33 on consecutive cycles; then rden for 3 cycles -> data 0x11/0x22/0x33 on the cycles after each rden; empty = 1 after the third read; word_count = 3.
- Write 512 words 0..511 -> full = 1 after the 512th. Write 0xDEAD -> dropped, overflow = 1. One read -> data = 0, full = 0 next cycle. Drain -> data 1..511; 0xDEAD is never seen.
- Write 4 words, drop user_w_hcw_open, read 4 -> eof = 1 the cycle after the FSM sees occ = 0, with empty = 1. Drop user_r_hcr_open -> eof = 0, FSM IDLE.
- occ = 1 (word 0xA); simultaneous wren(0xB) and rden -> occ stays 1, data = 0xA, next read -> 0xB. rden when empty -> underflow = 1, data holds 0xB.
- Close write with 2 words buffered, reopen before draining -> eof never asserts. word_count resets to 0, then counts new writes.
- 10 words buffered, eof path pending; pulse reset -> next cycle empty = 1, full = 0, eof = 0, word_count = 0, flags = 0.
